key_event_gen: RTL

Front-panel key conditioner between the four board push-buttons and the equalizer control FSM in `top`, replacing the per-key debounce instances. It synchronizes and debounces the active-low KEY levels, emits one-cycle press pulses for select/back/up/down, and auto-repeats up/down while held so gain can be swept without repeated presses. It runs entirely on the audio bit clock domain that `top` uses.

---
 rtl/key_event_gen.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/key_event_gen.sv
// -----------------------------------------------------------------------------
// key_event_gen
//   Front-panel key conditioner for the four board push-buttons. Each raw,
//   active-low KEY pin is synchronized, debounced, and turned into a one-cycle
//   press pulse. Up/down optionally auto-repeat while held so gain can be
//   swept without repeated presses. Everything runs on the audio bit clock.
//
//   Optional feature macro: AUTO_REPEAT_EN
//     defined   : shared up/down repeat FSM (IDLE -> DELAY -> REPEAT)
//     undefined : up/down pulse once per press, exactly like select/back
//
// Ports
//   i_clk     in   1  audio bit clock, rising edge
//   i_rst_n   in   1  asynchronous active-low reset
//   i_key_n   in   4  raw KEY pins, active-low (3=select 2=back 1=up 0=down)
//   o_select  out  1  one-cycle press pulse
//   o_back    out  1  one-cycle press pulse
//   o_up      out  1  one-cycle press or repeat pulse
//   o_down    out  1  one-cycle press or repeat pulse
//   o_level   out  4  debounced levels, active-high, same bit order
// -----------------------------------------------------------------------------
module key_event_gen #(
  parameter int unsigned DEB_CYCLES    = 65536,
  parameter int unsigned REPEAT_DELAY  = 1536000,
  parameter int unsigned REPEAT_PERIOD = 307200
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_key_n,
  output logic       o_select,
  output logic       o_back,
  output logic       o_up,
  output logic       o_down,
  output logic [3:0] o_level
);

  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [3:0]            sync1_q, sync2_q;
  logic [3:0]            stab_n_q, stab_n_d;
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]            level_q;
  logic [3:0]            press_ev, release_ev;
  logic                  select_q, back_q, up_q, down_q;
  logic                  up_d, down_d;

  // ---------------------------------------------------------------------------
  // Debounce: a key change is accepted only after the synchronized level has
  // differed from the stable level for DEB_CYCLES consecutive cycles.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    stab_n_d = stab_n_q;
    for (int k = 0; k < 4; k++) begin
      cnt_d[k] = '0;
      if (sync2_q[k] != stab_n_q[k]) begin
        if (cnt_q[k] == CNT_MAX) begin
          stab_n_d[k] = sync2_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end
    end
  end

  // level_q is the stable level one cycle late, so comparing the two gives the
  // edge without a separate history register.
  assign press_ev   = ~stab_n_q & ~level_q;
  assign release_ev =  stab_n_q &  level_q;

`ifdef AUTO_REPEAT_EN
  // ---------------------------------------------------------------------------
  // Shared up/down repeat engine. One owner at a time; the other repeat key is
  // ignored (not queued) until it is released and pressed again.
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } rpt_state_e;

  localparam int unsigned TMR_W = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
  localparam logic [TMR_W-1:0] DELAY_MAX  = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] PERIOD_MAX = TMR_W'(REPEAT_PERIOD - 1);

  rpt_state_e       state_q, state_d;
  logic             owner_up_q, owner_up_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             owner_rel;
  logic [TMR_W-1:0] tmr_limit;

  assign owner_rel = owner_up_q ? release_ev[1] : release_ev[0];
  assign tmr_limit = (state_q == ST_DELAY) ? DELAY_MAX : PERIOD_MAX;

  always_comb begin
    state_d    = state_q;
    owner_up_d = owner_up_q;
    tmr_d      = tmr_q + 1'b1;
    up_d       = 1'b0;
    down_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tmr_d = '0;
        // Up wins a same-cycle tie; down's press is simply dropped.
        if (press_ev[1]) begin
          up_d       = 1'b1;
          owner_up_d = 1'b1;
          state_d    = ST_DELAY;
        end else if (press_ev[0]) begin
          down_d     = 1'b1;
          owner_up_d = 1'b0;
          state_d    = ST_DELAY;
        end
      end
      ST_DELAY, ST_REPEAT: begin
        // Release takes priority, so a repeat due in the same cycle is lost.
        if (owner_rel) begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end else if (tmr_q == tmr_limit) begin
          up_d    = owner_up_q;
          down_d  = ~owner_up_q;
          tmr_d   = '0;
          state_d = ST_REPEAT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      owner_up_q <= 1'b0;
      tmr_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_up_q <= owner_up_d;
      tmr_q      <= tmr_d;
    end
  end
`else
  // Repeat timing has no meaning without the repeat engine.
  localparam bit unused_rpt_cfg = (REPEAT_DELAY != 0) || (REPEAT_PERIOD != 0);

  always_comb begin
    up_d   = press_ev[1];
    down_d = press_ev[0];
  end
`endif

  // ---------------------------------------------------------------------------
  // Synchronizers, debounce state and registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      stab_n_q <= '1;
      cnt_q    <= '0;
      level_q  <= '0;
      select_q <= 1'b0;
      back_q   <= 1'b0;
      up_q     <= 1'b0;
      down_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make the two sync stages a true shift.
      sync1_q  <= i_key_n;
      sync2_q  <= sync1_q;
      stab_n_q <= stab_n_d;
      cnt_q    <= cnt_d;
      level_q  <= ~stab_n_q;
      select_q <= press_ev[3];
      back_q   <= press_ev[2];
      up_q     <= up_d;
      down_q   <= down_d;
    end
  end

  assign o_select = select_q;
  assign o_back   = back_q;
  assign o_up     = up_q;
  assign o_down   = down_q;
  assign o_level  = level_q;

endmodule
